// File: rtl/cbus_arb_pkg.sv
// Shared types and helpers for the cache-bus arbiter: bus request/response
// structs, FSM state encoding and the rotate-and-find-first search.
package cbus_arb_pkg;

  // Largest supported number of requesters and the index width that covers it
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  // Burst length field (len = beats - 1) and a beat counter one bit wider
  localparam int LEN_W  = 4;
  localparam int BEAT_W = LEN_W + 1;

  // Cache-side request towards memory
  typedef struct packed {
    logic             valid;
    logic             is_write;
    logic [2:0]       size;
    logic [31:0]      addr;
    logic [3:0]       strobe;
    logic [31:0]      data;
    logic [LEN_W-1:0] len;
  } cbus_req_t;

  // Memory-side response towards a cache
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  // Search the request vector starting at 'start', wrapping modulo 'num',
  // and return the first requesting index (0 when nothing requests).
  function automatic logic [IDX_W-1:0] rr_find_first(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   start,
    input int unsigned        num
  );
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   cand;
    logic             found;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < num) begin
        cand = {1'b0, start} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(num)) begin
          cand = cand - (IDX_W+1)'(num);
        end else begin
          cand = cand;
        end
        if (!found && req[cand[IDX_W-1:0]]) begin
          idx   = cand[IDX_W-1:0];
          found = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational winner selection for the cache-bus arbiter. With RR_EN set
// the search begins one past the previous owner; otherwise index 0 has the
// highest priority.
module rr_picker
  import cbus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int RR_EN   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [MAX_REQ-1:0] req_pad_s;
  logic [IDX_W-1:0]   start_s;

  // Pick the search origin and run the wrap-around first-set search
  always_comb begin
    req_pad_s                = '0;
    req_pad_s[NUM_REQ-1:0]   = req_i;
    start_s                  = '0;
    if (RR_EN != 0) begin
      if (last_owner_i >= IDX_W'(NUM_REQ - 1)) begin
        start_s = '0;
      end else begin
        start_s = last_owner_i + IDX_W'(1);
      end
    end else begin
      start_s = '0;
    end
    valid_o = |req_i;
    idx_o   = rr_find_first(req_pad_s, start_s, NUM_REQ);
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: grants the single memory-side bus to one cache at a
// time, keeps the grant for the whole burst, routes responses only to the
// owner and flags bursts whose beat count disagrees with the requested len.
module cbus_arbiter
  import cbus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int RR_EN   = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireqs  [NUM_REQ],
  output cbus_resp_t oresps [NUM_REQ],
  output cbus_req_t  oreq,
  input  cbus_resp_t iresp,
  output logic       len_err
);

  localparam int REQ_W = $bits(cbus_req_t);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  last_owner_q, last_owner_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  exp_len_q, exp_len_d;
  logic              len_err_q, len_err_d;

  logic [NUM_REQ-1:0] req_vec_s;
  logic               win_valid_s;
  logic [IDX_W-1:0]   win_idx_s;
  cbus_req_t          sel_req_s;

  // Collect the valid bits of all requesters into one vector
  always_comb begin
    req_vec_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vec_s[i] = ireqs[i].valid;
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .RR_EN   (RR_EN)
  ) u_picker (
    .req_i        (req_vec_s),
    .last_owner_i (last_owner_q),
    .valid_o      (win_valid_s),
    .idx_o        (win_idx_s)
  );

  // Select the current owner's request with an AND-OR mux
  always_comb begin
    sel_req_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_req_s = sel_req_s | (ireqs[i] & {REQ_W{sel_q == IDX_W'(i)}});
    end
  end

  // Arbitration FSM, beat counting and length check
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    exp_len_d    = exp_len_q;
    len_err_d    = len_err_q;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          sel_d   = win_idx_s;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        beat_cnt_d = '0;
        exp_len_d  = sel_req_s.len;
        state_d    = BUSY;
      end
      BUSY: begin
        if (iresp.ready) begin
          // Saturate rather than wrap so an overlong burst still mismatches
          if (beat_cnt_q != {BEAT_W{1'b1}}) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end else begin
            beat_cnt_d = beat_cnt_q;
          end
          if (iresp.last) begin
            if (beat_cnt_q != {1'b0, exp_len_q}) begin
              len_err_d = 1'b1;
            end else begin
              len_err_d = len_err_q;
            end
            last_owner_d = sel_q;
            state_d      = IDLE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset makes index 0 the first round-robin winner
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      exp_len_q    <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      exp_len_q    <= exp_len_d;
      len_err_q    <= len_err_d;
    end
  end

  // Pass the owner's request through while busy, zeros otherwise
  always_comb begin
    if (state_q == BUSY) begin
      oreq = sel_req_s;
    end else begin
      oreq = '0;
    end
  end

  // Route memory responses only to the owner during the burst
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == BUSY) && (sel_q == IDX_W'(i))) begin
        oresps[i] = iresp;
      end else begin
        oresps[i] = '0;
      end
    end
  end

  assign len_err = len_err_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus; expected values are written out by hand.
module tb_cbus_arbiter;
  import cbus_arb_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  ireqs [2];
  cbus_resp_t oresps_m [2];
  cbus_resp_t oresps_f [2];
  cbus_req_t  oreq_m, oreq_f;
  cbus_resp_t iresp;
  logic       len_err_m, len_err_f;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_REQ(2), .RR_EN(1)) dut (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .oresps(oresps_m),
    .oreq(oreq_m), .iresp(iresp), .len_err(len_err_m)
  );

  cbus_arbiter #(.NUM_REQ(2), .RR_EN(0)) dut_fp (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .oresps(oresps_f),
    .oreq(oreq_f), .iresp(iresp), .len_err(len_err_f)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [3:0] strb,
                                       input logic [3:0] len);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'd2;
    r.addr     = addr;
    r.strobe   = strb;
    r.data     = data;
    r.len      = len;
    return r;
  endfunction

  // Drive one memory beat (caller is at a falling edge) and check routing
  task automatic beat(input int owner, input logic lst, input logic [31:0] d, input string tag);
    iresp.ready = 1'b1;
    iresp.last  = lst;
    iresp.data  = d;
    #1;
    check({tag, "_rdy"},   96'(oresps_m[owner].ready), 96'(1'b1));
    check({tag, "_last"},  96'(oresps_m[owner].last),  96'(lst));
    check({tag, "_dat"},   96'(oresps_m[owner].data),  96'(d));
    check({tag, "_other"}, 96'(oresps_m[1-owner]),     96'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn   = 1'b0;
    ireqs[0] = '0;
    ireqs[1] = '0;
    iresp    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_oreq",   96'(oreq_m),      96'(0));
    check("rst_resp0",  96'(oresps_m[0]), 96'(0));
    check("rst_resp1",  96'(oresps_m[1]), 96'(0));
    check("rst_lenerr", 96'(len_err_m),   96'(1'b0));
    resetn = 1'b1;
    @(negedge clk);

    // Test 1: single read by requester 1, len=3, four beats
    @(negedge clk);
    ireqs[1] = mk_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, 4'd3);
    @(negedge clk); #1;
    check("t1_grant_idle", 96'(oreq_m.valid), 96'(1'b0));
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 0) begin
        #1;
        check("t1_oreq_valid", 96'(oreq_m.valid), 96'(1'b1));
        check("t1_oreq_addr",  96'(oreq_m.addr),  96'(32'h0000_1000));
      end
      beat(1, (b == 3), 32'hA000_0000 + 32'(b), "t1_beat");
    end
    @(negedge clk);
    iresp = '0;
    #1;
    check("t1_back_idle", 96'(oreq_m.valid), 96'(1'b0));
    check("t1_lenerr",    96'(len_err_m),    96'(1'b0));
    ireqs[1] = '0;

    // Test 2: both requesting continuously, single-beat bursts
    @(negedge clk);
    ireqs[0] = mk_req(1'b0, 32'h0000_2000, 32'h0, 4'h0, 4'd0);
    ireqs[1] = mk_req(1'b0, 32'h0000_3000, 32'h0, 4'h0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      int e;
      e = k % 2;
      @(negedge clk); #1;
      check("t2_grant_idle", 96'(oreq_m.valid), 96'(1'b0));
      @(negedge clk); #1;
      check("t2_rr_addr", 96'(oreq_m.addr), 96'((e == 0) ? 32'h0000_2000 : 32'h0000_3000));
      check("t2_fp_addr", 96'(oreq_f.addr), 96'(32'h0000_2000));
      iresp.ready = 1'b1;
      iresp.last  = 1'b1;
      iresp.data  = 32'hB000_0000 + 32'(k);
      #1;
      check("t2_rr_win_rdy",  96'(oresps_m[e].ready),   96'(1'b1));
      check("t2_rr_lose_rdy", 96'(oresps_m[1-e].ready), 96'(1'b0));
      check("t2_fp_win_rdy",  96'(oresps_f[0].ready),   96'(1'b1));
      check("t2_fp_lose",     96'(oresps_f[1]),         96'(0));
      @(negedge clk);
      iresp = '0;
      #1;
      check("t2_idle", 96'(oreq_m.valid), 96'(1'b0));
      if (k == 3) begin
        ireqs[0] = '0;
        ireqs[1] = '0;
      end
    end

    // Test 3: requester 1 arrives during requester 0's 8-beat burst
    @(negedge clk);
    ireqs[0] = mk_req(1'b0, 32'h0000_4000, 32'h0, 4'h0, 4'd7);
    @(negedge clk); #1;
    check("t3_grant_idle", 96'(oreq_m.valid), 96'(1'b0));
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == 2) begin
        ireqs[1] = mk_req(1'b0, 32'h0000_5000, 32'h0, 4'h0, 4'd0);
      end
      beat(0, (b == 7), 32'hC000_0000 + 32'(b), "t3_beat");
      check("t3_owner_addr", 96'(oreq_m.addr), 96'(32'h0000_4000));
    end
    @(negedge clk);
    iresp = '0;
    #1;
    check("t3_idle",     96'(oreq_m.valid), 96'(1'b0));
    check("t3_lenerr",   96'(len_err_m),    96'(1'b0));
    ireqs[0] = '0;
    @(negedge clk); #1;
    check("t3_r1_grant", 96'(oreq_m.valid), 96'(1'b0));
    @(negedge clk); #1;
    check("t3_r1_valid", 96'(oreq_m.valid), 96'(1'b1));
    check("t3_r1_addr",  96'(oreq_m.addr),  96'(32'h0000_5000));
    beat(1, 1'b1, 32'hC100_0000, "t3_r1_beat");
    @(negedge clk);
    iresp = '0;
    #1;
    check("t3_r1_idle", 96'(oreq_m.valid), 96'(1'b0));
    ireqs[1] = '0;

    // Test 4: len=3 but last arrives on the second beat
    @(negedge clk);
    ireqs[0] = mk_req(1'b0, 32'h0000_6000, 32'h0, 4'h0, 4'd3);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      beat(0, (b == 1), 32'hD000_0000 + 32'(b), "t4_beat");
    end
    @(negedge clk);
    iresp = '0;
    #1;
    check("t4_idle",   96'(oreq_m.valid), 96'(1'b0));
    check("t4_lenerr", 96'(len_err_m),    96'(1'b1));
    ireqs[0] = '0;
    @(negedge clk); #1;
    check("t4_lenerr_sticky", 96'(len_err_m), 96'(1'b1));

    // Test 5: reset asserted on the third beat of a 4-beat burst
    @(negedge clk);
    ireqs[1] = mk_req(1'b0, 32'h0000_7000, 32'h0, 4'h0, 4'd3);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      beat(1, 1'b0, 32'hE000_0000 + 32'(b), "t5_beat");
    end
    check("t5_lenerr_before", 96'(len_err_m), 96'(1'b1));
    @(negedge clk);
    resetn      = 1'b0;
    iresp.ready = 1'b1;
    iresp.last  = 1'b0;
    iresp.data  = 32'hE000_0002;
    #1;
    check("t5_rst_oreq",   96'(oreq_m.valid), 96'(1'b0));
    check("t5_rst_resp1",  96'(oresps_m[1]),  96'(0));
    check("t5_rst_lenerr", 96'(len_err_m),    96'(1'b0));
    ireqs[1] = '0;
    iresp    = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("t5_post_resp0", 96'(oresps_m[0]),  96'(0));
    check("t5_post_resp1", 96'(oresps_m[1]),  96'(0));
    check("t5_post_oreq",  96'(oreq_m.valid), 96'(1'b0));

    // Test 6: single-beat write by requester 0 after reset
    @(negedge clk);
    ireqs[0] = mk_req(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'b1111, 4'd0);
    @(negedge clk); #1;
    check("t6_grant_idle", 96'(oreq_m.valid), 96'(1'b0));
    @(negedge clk); #1;
    check("t6_valid",  96'(oreq_m.valid),    96'(1'b1));
    check("t6_write",  96'(oreq_m.is_write), 96'(1'b1));
    check("t6_addr",   96'(oreq_m.addr),     96'(32'h0000_1234));
    check("t6_data",   96'(oreq_m.data),     96'(32'hDEAD_BEEF));
    check("t6_strobe", 96'(oreq_m.strobe),   96'(4'b1111));
    check("t6_len",    96'(oreq_m.len),      96'(4'd0));
    beat(0, 1'b1, 32'h0000_0000, "t6_beat");
    @(negedge clk);
    iresp = '0;
    #1;
    check("t6_done_idle", 96'(oreq_m.valid), 96'(1'b0));
    check("t6_lenerr",    96'(len_err_m),    96'(1'b0));
    ireqs[0] = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
